// File: rtl/pwr_cntr_bank.sv
// pwr_cntr_bank: bank of NCH saturating edge counters used for power
// estimation of library cells under test. Channels are read back one at a
// time through an RD/DIR request that answers with a single-cycle VALID
// pulse. The first clock edge after reset only arms the edge detector.
//
// Optional feature, guarded by the macro PWR_CNTR_SNAPSHOT_EN: adds a SNAP
// input and a shadow copy of all counters and overflow flags. Reads then
// return the shadow contents instead of the live counters.
module pwr_cntr_bank #(
  parameter int NCH  = 5,   // monitored channels, 1..256
  parameter int W    = 32,  // counter width, 4..32
  parameter int AW   = 3,   // address width, 2**AW >= NCH
  parameter int MODE = 0    // 0: both edges, 1: rising edges only
) (
  input  logic           CLK,
  input  logic           RESET_N,
  input  logic           ENB,
  input  logic [NCH-1:0] SIG,
  input  logic           CLR,
  input  logic           RD,
  input  logic [AW-1:0]  DIR,
`ifdef PWR_CNTR_SNAPSHOT_EN
  input  logic           SNAP,
`endif
  output logic [W-1:0]   DATO,
  output logic           VALID,
  output logic           OVF,
  output logic           ERR
);

  logic [NCH-1:0] prev_q;
  logic           arm_q;
  logic [NCH-1:0] edge_vec;
  logic [W-1:0]   cnt_q [NCH];
  logic [W-1:0]   cnt_d [NCH];
  logic [NCH-1:0] ovf_q;
  logic [NCH-1:0] ovf_d;

  // Read request stage (captured on the RD edge) and output stage.
  logic           rd_pend_q;
  logic [W-1:0]   rd_dat_q;
  logic           rd_ovf_q;
  logic           rd_err_q;
  logic           valid_q;
  logic [W-1:0]   dato_q;
  logic           ovf_out_q;
  logic           err_q;

  // Combinational read-select result.
  logic [W-1:0]   sel_cnt;
  logic           sel_ovf;
  logic           sel_hit;

`ifdef PWR_CNTR_SNAPSHOT_EN
  logic [W-1:0]   shd_q [NCH];
  logic [NCH-1:0] shd_ovf_q;
`endif

  // Edge detection and next-state of every counter: CLR wins over counting,
  // counting saturates at all-ones and raises the sticky overflow flag.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    edge_vec = (MODE == 1) ? (SIG & ~prev_q) : (SIG ^ prev_q);
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      ovf_d[i] = ovf_q[i];
      if (CLR) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (ENB && arm_q && edge_vec[i]) begin
        if (&cnt_q[i]) ovf_d[i] = 1'b1;
        else           cnt_d[i] = cnt_q[i] + W'(1);
      end
    end
  end

  // Counter, overflow, previous-sample and arm registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      prev_q <= '0;
      arm_q  <= 1'b0;
      ovf_q  <= '0;
      // NOTE: the counter array is a register file that must read zero after
      // reset, so each entry is reset explicitly rather than left to a RAM.
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from
      // pre-edge values, which is what gives reads their pre-update snapshot.
      prev_q <= SIG;
      arm_q  <= 1'b1;
      ovf_q  <= ovf_d;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef PWR_CNTR_SNAPSHOT_EN
  // Shadow copy of all live counters, taken atomically on SNAP; CLR leaves it alone.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      shd_ovf_q <= '0;
      for (int i = 0; i < NCH; i++) shd_q[i] <= '0;
    end else if (SNAP) begin
      shd_ovf_q <= ovf_q;
      for (int i = 0; i < NCH; i++) shd_q[i] <= cnt_q[i];
    end
  end
`endif

  // Select the addressed channel; an address with no matching channel is out of range.
  always_comb begin
    sel_cnt = '0;
    sel_ovf = 1'b0;
    sel_hit = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (DIR == AW'(i)) begin
        sel_hit = 1'b1;
`ifdef PWR_CNTR_SNAPSHOT_EN
        sel_cnt = shd_q[i];
        sel_ovf = shd_ovf_q[i];
`else
        sel_cnt = cnt_q[i];
        sel_ovf = ovf_q[i];
`endif
      end
    end
  end

  // Two-stage read pipeline: capture on the RD edge, present with VALID on the next.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rd_pend_q <= 1'b0;
      rd_dat_q  <= '0;
      rd_ovf_q  <= 1'b0;
      rd_err_q  <= 1'b0;
      valid_q   <= 1'b0;
      dato_q    <= '0;
      ovf_out_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rd_pend_q <= RD;
      if (RD) begin
        rd_dat_q <= sel_cnt;
        rd_ovf_q <= sel_ovf;
        rd_err_q <= ~sel_hit;
      end
      valid_q <= rd_pend_q;
      if (rd_pend_q) begin
        dato_q    <= rd_dat_q;
        ovf_out_q <= rd_ovf_q;
        err_q     <= rd_err_q;
      end
    end
  end

  assign DATO  = dato_q;
  assign VALID = valid_q;
  assign OVF   = ovf_out_q;
  assign ERR   = err_q;

endmodule

// File: doc/pwr_cntr_bank.md
Name: pwr_cntr_bank

Overview:
- Parametrised bank of per-channel activity (toggle) counters for power estimation of library cells under test.
- Watches NCH single-bit signals, e.g. outputs of NOT/NAND/NOR/MUX/flip-flop cells.
- Counts edges per channel while enabled; results are read back one channel at a time through an addressed request/valid handshake.
- Sits beside the cells under test; driven by the bench or a later on-chip monitor.

Parameters:
- NCH, 5, number of monitored channels (1..256).
- W, 32, counter width in bits (4..32).
- AW, 3, address width; must satisfy 2**AW >= NCH.
- MODE, 0, edge mode: 0 counts both edges, 1 counts rising edges only.

Ports:
- CLK  input  1  clock; all state updates on its rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- ENB  input  1  count enable, level-sensitive.
- SIG  input  NCH  monitored signals, already synchronous to CLK.
- CLR  input  1  synchronous clear of all counters and overflow flags.
- RD  input  1  read request, sampled each cycle.
- DIR  input  AW  channel address for RD.
- DATO  output  W  read data.
- VALID  output  1  one-cycle pulse marking DATO valid.
- OVF  output  1  sticky overflow flag of the channel read, qualified by VALID.
- ERR  output  1  address-out-of-range flag, qualified by VALID.

Behaviour:
- Reset (RESET_N=0, asynchronous):
  - Clears all counters, overflow flags, previous-sample register and arm flag.
  - Drives DATO=0, VALID=0, OVF=0, ERR=0.
  - A reset asserted mid-read cancels the read: VALID stays 0.
- Arm flag:
  - The first rising edge of CLK after RESET_N deasserts only loads the previous-sample register from SIG and sets arm.
  - No counting occurs on that edge, so a signal that is high at reset release is not counted.
- Edge detection per channel i:
  - MODE=0: edge = SIG[i] XOR prev[i].
  - MODE=1: edge = SIG[i] AND NOT prev[i].
  - prev updates every cycle regardless of ENB.
- Counting:
  - When ENB=1, arm=1 and edge[i]=1, counter[i] increments by 1.
  - Counting is saturating: at 2**W-1 the counter holds its value and sets the sticky ovf[i].
  - ENB=0 freezes all counters.
- Clear:
  - CLR=1 zeroes all counters and ovf flags on the next edge.
  - CLR takes priority over a simultaneous increment.
  - prev and arm are not affected by CLR.
- Read:
  - RD=1 at edge k captures DIR.
  - At edge k+1: VALID=1 for exactly one cycle, DATO=counter[DIR], OVF=ovf[DIR], ERR=0. Latency is one cycle.
  - The returned value is the counter as it stood before any increment or CLR at edge k (pre-update snapshot).
  - Back-to-back RD on consecutive cycles is allowed; each produces its own VALID pulse, so throughput is one read per cycle.
- Out of range:
  - DIR >= NCH returns DATO=0, OVF=0, ERR=1 with VALID=1.
- Output holding:
  - When VALID=0, DATO, OVF and ERR hold their last values.

Optional Feature:
- Macro: PWR_CNTR_SNAPSHOT_EN.
- When defined:
  - Adds input SNAP (1 bit) and a shadow register set of NCH x W plus NCH overflow bits.
  - SNAP=1 copies all live counters and ovf flags to the shadow atomically on one edge; reads return shadow contents.
  - Shadow resets to 0; CLR does not clear the shadow.
  - SNAP and RD in the same cycle: the read returns the pre-snapshot shadow.
- When undefined:
  - No SNAP port, no shadow storage; reads return live counters as specified above.

Test Plan:
- Reset release with SIG=5'b11111, ENB=1, no further toggles for 10 cycles -> all counters read 0 (arm suppresses the initial edge).
- MODE=0, ENB=1, SIG[0] toggled every cycle for 10 cycles, then RD with DIR=0 -> VALID one cycle later, DATO=10, OVF=0, ERR=0; with MODE=1 the same stimulus -> DATO=5.
- W=4, SIG[2] toggled 20 times with ENB=1 -> DATO=15, OVF=1; then CLR pulse and re-read -> DATO=0, OVF=0.
- ENB=0 while toggling SIG[1] 8 times, then ENB=1 and 3 more toggles -> DATO=3.
- RD with DIR=7 on NCH=5 -> VALID=1, ERR=1, DATO=0; back-to-back RD of DIR=0,1,2 -> three consecutive VALID pulses with the matching values.
- RESET_N pulsed low during the cycle after RD -> VALID never asserts and all counters read 0 afterwards; with PWR_CNTR_SNAPSHOT_EN, SNAP at count 6, then 4 more toggles -> read returns 6.
